// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath/memory.
// The controller uses the master modport; the datapath side uses slave.
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             alu_zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             pc_we;
  logic             Branch;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemToReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             PCSource;
  logic             instr_retired;
  logic [CNT_W-1:0] retired_count;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [3:0]       state;

  modport master (
    input  opcode, alu_zero, mem_ready,
    output PCWrite, pc_we, Branch, IorD, MemRead, MemWrite, IRWrite,
           MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_retired, retired_count, trap, trap_cause, state
  );

  modport slave (
    output opcode, alu_zero, mem_ready,
    input  PCWrite, pc_we, Branch, IorD, MemRead, MemWrite, IRWrite,
           MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_retired, retired_count, trap, trap_cause, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencing
// with memory-ready handshake, wait timeout, illegal-opcode trap and retire counter.
module mips_multicycle_ctrl #(
  parameter logic [5:0] SUBI_OPCODE = 6'b001001,
  parameter int         TIMEOUT     = 255,
  parameter int         CNT_W       = 32
) (
  input logic clk,
  input logic rst,
  mips_multicycle_ctrl_if.master bus
);

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_IMM_EX   = 4'd8,
    S_IMM_WB   = 4'd9,
    S_BEQ_EX   = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t           state_q, state_nxt;
  logic [WCW-1:0]   wcnt_q;
  logic [CNT_W-1:0] retired_q;
  logic             trap_q;
  logic [1:0]       cause_q, cause_nxt;
  logic             timeout_hit, illegal_state;

  logic       pc_write, branch, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, pc_source, retire;
  logic [1:0] alu_src_b, alu_op;

  // Timeout fires only on a cycle that would otherwise keep waiting.
  assign timeout_hit   = (TIMEOUT != 0) && !bus.mem_ready && (wcnt_q == WCW'(TIMEOUT - 1));
  assign illegal_state = (state_q > S_TRAP);

  always_comb begin
    state_nxt  = state_q;
    cause_nxt  = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) begin
          state_nxt = S_DECODE;
        end else if (timeout_hit) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'b10;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (bus.opcode == OP_RTYPE)                          state_nxt = S_RTYPE_EX;
        else if (bus.opcode == OP_LW || bus.opcode == OP_SW) state_nxt = S_MEMADR;
        else if (bus.opcode == SUBI_OPCODE)                  state_nxt = S_IMM_EX;
        else if (bus.opcode == OP_BEQ)                       state_nxt = S_BEQ_EX;
        else begin
          state_nxt = S_TRAP;
          cause_nxt = 2'b01;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nxt = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          state_nxt = S_MEMWB;
        end else if (timeout_hit) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'b10;
        end
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (timeout_hit) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'b10;
        end
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_nxt = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_IMM_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_nxt = S_IMM_WB;
      end
      S_IMM_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BEQ_EX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        branch    = 1'b1;
        pc_source = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_TRAP: begin
        state_nxt = S_TRAP;
      end
      default: begin
        state_nxt = S_TRAP;
        cause_nxt = 2'b01;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wcnt_q    <= '0;
      retired_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q <= state_nxt;
      // Wait counter restarts on every state change and saturates while stuck.
      if (state_nxt != state_q)                  wcnt_q <= '0;
      else if (!bus.mem_ready && wcnt_q != '1)   wcnt_q <= wcnt_q + 1'b1;
      if (retire)                                retired_q <= retired_q + 1'b1;
      if (state_nxt == S_TRAP && state_q != S_TRAP) begin
        trap_q  <= 1'b1;
        cause_q <= cause_nxt;
      end
    end
  end

  // Write enables and requests are forced low during reset, same cycle.
  assign bus.PCWrite       = pc_write  & ~rst;
  assign bus.pc_we         = (pc_write | (branch & bus.alu_zero)) & ~rst;
  assign bus.IRWrite       = ir_write  & ~rst;
  assign bus.MemRead       = mem_read  & ~rst;
  assign bus.MemWrite      = mem_write & ~rst;
  assign bus.RegWrite      = reg_write & ~rst;
  assign bus.instr_retired = retire    & ~rst;
  assign bus.Branch        = branch;
  assign bus.IorD          = iord;
  assign bus.MemToReg      = mem_to_reg;
  assign bus.RegDst        = reg_dst;
  assign bus.ALUSrcA       = alu_src_a;
  assign bus.ALUSrcB       = alu_src_b;
  assign bus.ALUOp         = alu_op;
  assign bus.PCSource      = pc_source;
  assign bus.retired_count = retired_q;
  assign bus.trap          = trap_q | illegal_state;
  assign bus.trap_cause    = illegal_state ? 2'b01 : cause_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-cycle expected state/controls
// are queued when inputs are driven and compared against the DUT mid-cycle.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  logic [1:0] exp_cause = 2'b00;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if #(.CNT_W(32)) ifc ();
  mips_multicycle_ctrl_if #(.CNT_W(32)) ifc2 ();

  mips_multicycle_ctrl #(.SUBI_OPCODE(6'b001001), .TIMEOUT(255), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(ifc.master)
  );

  mips_multicycle_ctrl #(.SUBI_OPCODE(6'b001001), .TIMEOUT(4), .CNT_W(32)) dut_t (
    .clk(clk), .rst(rst2), .bus(ifc2.master)
  );

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] cnt;
    logic        trap;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Control word order: PCWrite pc_we Branch IorD MemRead MemWrite IRWrite
  // MemToReg RegDst RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource instr_retired
  function automatic logic [16:0] exp_ctl(input logic [3:0] st, input logic mr,
                                          input logic az, input logic r);
    logic pcw, pcwe, br, iord, mrd, mwr, irw, m2r, rdst, rw, sa, pcs, ret;
    logic [1:0] sb_, op;
    {pcw, pcwe, br, iord, mrd, mwr, irw, m2r, rdst, rw, sa, pcs, ret} = '0;
    sb_ = 2'b00; op = 2'b00;
    case (st)
      4'd0:  begin mrd = 1; sb_ = 2'b01; irw = mr; pcw = mr; pcwe = mr; end
      4'd1:  sb_ = 2'b11;
      4'd2:  begin sa = 1; sb_ = 2'b10; end
      4'd3:  begin iord = 1; mrd = 1; end
      4'd4:  begin m2r = 1; rw = 1; ret = 1; end
      4'd5:  begin iord = 1; mwr = 1; ret = mr; end
      4'd6:  begin sa = 1; op = 2'b10; end
      4'd7:  begin rdst = 1; rw = 1; ret = 1; end
      4'd8:  begin sa = 1; sb_ = 2'b10; op = 2'b11; end
      4'd9:  begin rw = 1; ret = 1; end
      4'd10: begin sa = 1; op = 2'b01; br = 1; pcs = 1; ret = 1; pcwe = az; end
      default: ;
    endcase
    if (r) {pcw, pcwe, irw, mrd, mwr, rw, ret} = '0;
    return {pcw, pcwe, br, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb_, op, pcs, ret};
  endfunction

  task automatic cyc(input logic mr, input logic az, input logic [3:0] est, input string tag);
    exp_t e;
    logic [16:0] got;
    ifc.mem_ready = mr;
    ifc.alu_zero  = az;
    e.st    = est;
    e.ctl   = exp_ctl(est, mr, az, rst);
    e.cnt   = exp_cnt;
    e.trap  = (est == 4'd11);
    e.cause = (est == 4'd11) ? exp_cause : 2'b00;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    got = {ifc.PCWrite, ifc.pc_we, ifc.Branch, ifc.IorD, ifc.MemRead, ifc.MemWrite,
           ifc.IRWrite, ifc.MemToReg, ifc.RegDst, ifc.RegWrite, ifc.ALUSrcA,
           ifc.ALUSrcB, ifc.ALUOp, ifc.PCSource, ifc.instr_retired};
    chk({tag, " state"}, 32'(ifc.state), 32'(e.st));
    chk({tag, " ctl"},   32'(got),       32'(e.ctl));
    chk({tag, " count"}, ifc.retired_count, e.cnt);
    chk({tag, " trap"},  32'(ifc.trap),  32'(e.trap));
    chk({tag, " cause"}, 32'(ifc.trap_cause), 32'(e.cause));
    if (rst)         exp_cnt = 0;
    else if (e.ctl[0]) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    ifc.opcode = 6'b000000; ifc.alu_zero = 1'b0; ifc.mem_ready = 1'b1;
    ifc2.opcode = 6'b000000; ifc2.alu_zero = 1'b0; ifc2.mem_ready = 1'b0;
    @(posedge clk); #1;

    // Timeout DUT: ready on the last allowed cycle wins.
    rst2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d state", i), 32'(ifc2.state), 32'd0);
      chk($sformatf("to_wait%0d memread", i), 32'(ifc2.MemRead), 32'd1);
      @(posedge clk); #1;
    end
    ifc2.mem_ready = 1'b1;
    @(negedge clk);
    chk("to_win irwrite", 32'(ifc2.IRWrite), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_win state", 32'(ifc2.state), 32'd1);
    chk("to_win trap", 32'(ifc2.trap), 32'd0);
    @(posedge clk); #1;
    rst2 = 1'b1; ifc2.mem_ready = 1'b0;
    @(posedge clk); #1;
    rst2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("to_fetch%0d state", i), 32'(ifc2.state), 32'd0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("to_trap%0d state", i), 32'(ifc2.state), 32'd11);
      chk($sformatf("to_trap%0d trap", i), 32'(ifc2.trap), 32'd1);
      chk($sformatf("to_trap%0d cause", i), 32'(ifc2.trap_cause), 32'd2);
      chk($sformatf("to_trap%0d memread", i), 32'(ifc2.MemRead), 32'd0);
      @(posedge clk); #1;
    end

    // Main DUT: reset cycle with enables forced low.
    cyc(1, 0, 4'd0, "reset");
    rst = 1'b0;

    ifc.opcode = 6'b000000;
    cyc(1, 0, 4'd0, "or0"); cyc(1, 0, 4'd1, "or1");
    cyc(1, 0, 4'd6, "or2"); cyc(1, 0, 4'd7, "or3");

    ifc.opcode = 6'b001001;
    cyc(1, 0, 4'd0, "subi0"); cyc(1, 0, 4'd1, "subi1");
    cyc(1, 0, 4'd8, "subi2"); cyc(1, 0, 4'd9, "subi3");

    ifc.opcode = 6'b101011;
    cyc(1, 0, 4'd0, "sw0"); cyc(1, 0, 4'd1, "sw1"); cyc(1, 0, 4'd2, "sw2");
    cyc(0, 0, 4'd5, "sw3"); cyc(0, 0, 4'd5, "sw4"); cyc(0, 0, 4'd5, "sw5");
    cyc(1, 0, 4'd5, "sw6");

    ifc.opcode = 6'b100011;
    cyc(0, 0, 4'd0, "lw0"); cyc(1, 0, 4'd0, "lw1"); cyc(1, 0, 4'd1, "lw2");
    cyc(1, 0, 4'd2, "lw3"); cyc(0, 0, 4'd3, "lw4"); cyc(1, 0, 4'd3, "lw5");
    cyc(1, 0, 4'd4, "lw6");

    ifc.opcode = 6'b000100;
    cyc(1, 1, 4'd0, "beqt0"); cyc(1, 1, 4'd1, "beqt1"); cyc(1, 1, 4'd10, "beqt2");
    cyc(1, 0, 4'd0, "beqn0"); cyc(1, 0, 4'd1, "beqn1"); cyc(1, 0, 4'd10, "beqn2");

    // Illegal opcode traps and holds until reset.
    ifc.opcode = 6'b111111;
    exp_cause = 2'b01;
    cyc(1, 0, 4'd0, "ill0"); cyc(1, 0, 4'd1, "ill1");
    for (int i = 0; i < 20; i++)
      cyc((i % 2) == 0, (i % 3) == 0, 4'd11, $sformatf("trap%0d", i));
    rst = 1'b1;
    cyc(1, 0, 4'd11, "trap_rst");
    rst = 1'b0;
    exp_cause = 2'b00;
    ifc.opcode = 6'b000000;
    cyc(1, 0, 4'd0, "after_trap0"); cyc(1, 0, 4'd1, "after_trap1");
    cyc(1, 0, 4'd6, "after_trap2"); cyc(1, 0, 4'd7, "after_trap3");

    // Reset while a store is waiting in MEMWR.
    ifc.opcode = 6'b101011;
    cyc(1, 0, 4'd0, "swr0"); cyc(1, 0, 4'd1, "swr1"); cyc(1, 0, 4'd2, "swr2");
    cyc(0, 0, 4'd5, "swr3");
    rst = 1'b1;
    cyc(1, 0, 4'd5, "swr_rst");
    rst = 1'b0;
    cyc(1, 0, 4'd0, "swr_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
